// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single regfile write port between the in-order
// writeback stage and the multi-cycle MDU. MDU results wait in a small FIFO
// and drain in cycles without a writeback write. A saturating starvation
// counter forces one FIFO grant (stalling writeback for a cycle) once the
// head has been denied MAX_WAIT times.
// Optional build macro: ORION_WB_ARB_PERF_EN adds two wrapping performance
// counters (perf_conflict_o, perf_stall_o).

module wb_port_arbiter #(
  parameter int XLEN        = 32,
  parameter int RF_IDX_BITS = 5,
  parameter int DEPTH       = 2,  // power of two, >= 2
  parameter int MAX_WAIT    = 4   // 1..15
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  // writeback stage
  input  logic                   pipe_we_i,
  input  logic [RF_IDX_BITS-1:0] pipe_rd_s_i,
  input  logic [XLEN-1:0]        pipe_rd_v_i,
  output logic                   pipe_stall_o,
  // MDU result bus
  input  logic                   mdu_valid_i,
  output logic                   mdu_ready_o,
  input  logic [RF_IDX_BITS-1:0] mdu_rd_s_i,
  input  logic [XLEN-1:0]        mdu_rd_v_i,
  // regfile write port
  output logic                   rf_we_o,
  output logic [RF_IDX_BITS-1:0] rf_rd_s_o,
  output logic [XLEN-1:0]        rf_rd_v_o,
`ifdef ORION_WB_ARB_PERF_EN
  output logic [31:0]            perf_conflict_o,
  output logic [31:0]            perf_stall_o,
`endif
  output logic                   mdu_pending_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [3:0]       MAX_WAIT_C = 4'(MAX_WAIT);

  typedef struct packed {
    logic [RF_IDX_BITS-1:0] rd_s;
    logic [XLEN-1:0]        rd_v;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       starve_q, starve_d;

  logic   fifo_empty;
  logic   fifo_full;
  logic   starved;
  logic   push;
  logic   pop;
  entry_t head;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == DEPTH_C);
  assign starved    = (starve_q == MAX_WAIT_C);
  assign head       = mem_q[rd_ptr_q];

  // x0 results complete the handshake but are never stored.
  assign push = mdu_valid_i && !fifo_full && (mdu_rd_s_i != '0);
  // Head wins whenever writeback is idle, or when it has waited long enough.
  assign pop  = !fifo_empty && (!pipe_we_i || starved);

  // Ready reflects only the registered fill level: a full FIFO refuses even
  // in the cycle it drains, which keeps ready off the grant path.
  assign mdu_ready_o   = !fifo_full;
  assign mdu_pending_o = !fifo_empty;

  // Port mux: select granted source and qualify the write against x0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    pipe_stall_o = 1'b0;
    rf_rd_s_o    = pipe_rd_s_i;
    rf_rd_v_o    = pipe_rd_v_i;
    if (pop) begin
      rf_rd_s_o    = head.rd_s;
      rf_rd_v_o    = head.rd_v;
      pipe_stall_o = pipe_we_i;  // only a forced grant can collide with a pipe write
    end
    rf_we_o = (pop || pipe_we_i) && (rf_rd_s_o != '0);
  end

  // Next-state for pointers, fill count and starvation counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (pipe_we_i && !starved) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk_i) begin
    // NOTE: storage has no reset; clearing the pointers and count already
    // discards stale entries, and an unreset array maps onto plain RAM/flops.
    if (push) begin
      mem_q[wr_ptr_q] <= '{rd_s: mdu_rd_s_i, rd_v: mdu_rd_v_i};
    end
  end

`ifdef ORION_WB_ARB_PERF_EN
  logic [31:0] perf_conflict_q;
  logic [31:0] perf_stall_q;

  // Wrapping event counters: port contention and forced stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_conflict_q <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_q + 32'(!fifo_empty && pipe_we_i);
      perf_stall_q    <= perf_stall_q + 32'(pipe_stall_o);
    end
  end

  assign perf_conflict_o = perf_conflict_q;
  assign perf_stall_o    = perf_stall_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed scenarios plus a randomized run,
// all checked against a queue-based reference model of the arbitration rules.

module tb_wb_port_arbiter;

  localparam int XLEN     = 32;
  localparam int RIB      = 5;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            pipe_we_i;
  logic [RIB-1:0]  pipe_rd_s_i;
  logic [XLEN-1:0] pipe_rd_v_i;
  logic            pipe_stall_o;
  logic            mdu_valid_i;
  logic            mdu_ready_o;
  logic [RIB-1:0]  mdu_rd_s_i;
  logic [XLEN-1:0] mdu_rd_v_i;
  logic            rf_we_o;
  logic [RIB-1:0]  rf_rd_s_o;
  logic [XLEN-1:0] rf_rd_v_o;
  logic            mdu_pending_o;
`ifdef ORION_WB_ARB_PERF_EN
  logic [31:0]     perf_conflict_o;
  logic [31:0]     perf_stall_o;
`endif

  wb_port_arbiter #(
    .XLEN(XLEN), .RF_IDX_BITS(RIB), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pipe_we_i(pipe_we_i), .pipe_rd_s_i(pipe_rd_s_i), .pipe_rd_v_i(pipe_rd_v_i),
    .pipe_stall_o(pipe_stall_o),
    .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o),
    .mdu_rd_s_i(mdu_rd_s_i), .mdu_rd_v_i(mdu_rd_v_i),
    .rf_we_o(rf_we_o), .rf_rd_s_o(rf_rd_s_o), .rf_rd_v_o(rf_rd_v_o),
`ifdef ORION_WB_ARB_PERF_EN
    .perf_conflict_o(perf_conflict_o), .perf_stall_o(perf_stall_o),
`endif
    .mdu_pending_o(mdu_pending_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [RIB-1:0]  rd_s;
    logic [XLEN-1:0] rd_v;
  } res_t;

  res_t        mq[$];       // queued MDU results, oldest first
  int          m_denied;    // times the current head has been passed over
  int unsigned m_conf;
  int unsigned m_stalls;

  logic            exp_we, exp_stall, exp_ready, exp_pend;
  logic [RIB-1:0]  exp_rd_s;
  logic [XLEN-1:0] exp_rd_v;
  int unsigned     exp_conf, exp_stalls;

  // Apply one cycle of inputs at the falling edge, derive the expected
  // outputs for this cycle from the model, then advance the model to the
  // state the DUT will hold after the next rising edge.
  task automatic drive(input logic rst, input logic pwe, input logic [RIB-1:0] prd,
                       input logic [XLEN-1:0] pv, input logic mv,
                       input logic [RIB-1:0] mrd, input logic [XLEN-1:0] mdv);
    logic busy, take_fifo;
    res_t r;
    @(negedge clk_i);
    rst_i = rst; pipe_we_i = pwe; pipe_rd_s_i = prd; pipe_rd_v_i = pv;
    mdu_valid_i = mv; mdu_rd_s_i = mrd; mdu_rd_v_i = mdv;
    #1;
    busy       = (mq.size() != 0);
    take_fifo  = busy && (!pwe || m_denied >= MAX_WAIT);
    exp_stall  = busy && pwe && (m_denied >= MAX_WAIT);
    exp_rd_s   = take_fifo ? mq[0].rd_s : prd;
    exp_rd_v   = take_fifo ? mq[0].rd_v : pv;
    exp_we     = (take_fifo || pwe) && (exp_rd_s != 0);
    exp_ready  = (mq.size() < DEPTH);
    exp_pend   = busy;
    exp_conf   = m_conf;
    exp_stalls = m_stalls;
    if (rst) begin
      mq.delete();
      m_denied = 0; m_conf = 0; m_stalls = 0;
    end else begin
      if (busy && pwe) m_conf++;
      if (exp_stall) m_stalls++;
      if (take_fifo) begin
        void'(mq.pop_front());
        m_denied = 0;
      end else if (busy) begin
        m_denied++;
      end
      if (mv && exp_ready && mrd != 0) begin
        r.rd_s = mrd; r.rd_v = mdv;
        mq.push_back(r);
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    idle();
    n_cmp++; if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got=%b exp=0", rf_we_o); end
    n_cmp++; if (pipe_stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", pipe_stall_o); end
    n_cmp++; if (mdu_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b exp=1", mdu_ready_o); end
    n_cmp++; if (mdu_pending_o !== 1'b0) begin n_err++; $display("FAIL reset_pending got=%b exp=0", mdu_pending_o); end
  endtask

  task automatic test_single_mdu();
    do_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 32'h1234);
    n_cmp++; if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL single_c0_we got=%b exp=0", rf_we_o); end
    idle();
    n_cmp++; if (rf_we_o !== 1'b1) begin n_err++; $display("FAIL single_c1_we got=%b exp=1", rf_we_o); end
    n_cmp++; if (rf_rd_s_o !== 5'd5) begin n_err++; $display("FAIL single_c1_rd got=%0d exp=5", rf_rd_s_o); end
    n_cmp++; if (rf_rd_v_o !== 32'h1234) begin n_err++; $display("FAIL single_c1_data got=%h exp=1234", rf_rd_v_o); end
    n_cmp++; if (mdu_pending_o !== 1'b1) begin n_err++; $display("FAIL single_c1_pending got=%b exp=1", mdu_pending_o); end
    idle();
    n_cmp++; if (mdu_pending_o !== 1'b0) begin n_err++; $display("FAIL single_c2_pending got=%b exp=0", mdu_pending_o); end
    n_cmp++; if (rf_we_o !== 1'b0) begin n_err++; $display("FAIL single_c2_we got=%b exp=0", rf_we_o); end
  endtask

  task automatic test_starvation();
    logic [XLEN-1:0] pv;
    do_reset();
    pv = $urandom;
    drive(1'b0, 1'b1, 5'd3, pv, 1'b1, 5'd7, 32'hA5A5_0007);
    n_cmp++; if (rf_rd_s_o !== 5'd3 || pipe_stall_o !== 1'b0) begin
      n_err++; $display("FAIL starve_c0 rd=%0d stall=%b exp rd=3 stall=0", rf_rd_s_o, pipe_stall_o);
    end
    for (int k = 1; k <= MAX_WAIT; k++) begin
      drive(1'b0, 1'b1, 5'd3, pv, 1'b0, '0, '0);
      n_cmp++; if (rf_rd_s_o !== 5'd3 || rf_rd_v_o !== pv || rf_we_o !== 1'b1 || pipe_stall_o !== 1'b0) begin
        n_err++; $display("FAIL starve_denied_%0d rd=%0d we=%b stall=%b exp rd=3 we=1 stall=0",
                          k, rf_rd_s_o, rf_we_o, pipe_stall_o);
      end
    end
    drive(1'b0, 1'b1, 5'd3, pv, 1'b0, '0, '0);
    n_cmp++; if (pipe_stall_o !== 1'b1 || rf_rd_s_o !== 5'd7 || rf_rd_v_o !== 32'hA5A5_0007 || rf_we_o !== 1'b1) begin
      n_err++; $display("FAIL starve_forced stall=%b rd=%0d data=%h we=%b exp stall=1 rd=7 data=a5a50007 we=1",
                        pipe_stall_o, rf_rd_s_o, rf_rd_v_o, rf_we_o);
    end
    drive(1'b0, 1'b1, 5'd3, pv, 1'b0, '0, '0);
    n_cmp++; if (pipe_stall_o !== 1'b0 || rf_rd_s_o !== 5'd3 || mdu_pending_o !== 1'b0) begin
      n_err++; $display("FAIL starve_after stall=%b rd=%0d pend=%b exp stall=0 rd=3 pend=0",
                        pipe_stall_o, rf_rd_s_o, mdu_pending_o);
    end
  endtask

  task automatic test_back_to_back();
    int idx = 1;
    int retired[$];
    logic mv;
    do_reset();
    for (int cyc = 0; cyc < 40 && retired.size() < 3; cyc++) begin
      mv = (idx <= 3);
      drive(1'b0, 1'b1, 5'd9, 32'h9, mv, 5'(idx), 32'h100 + 32'(idx));
      if (cyc == 2) begin
        n_cmp++; if (mdu_ready_o !== 1'b0 || idx != 3) begin
          n_err++; $display("FAIL b2b_full ready=%b accepted=%0d exp ready=0 accepted=2", mdu_ready_o, idx - 1);
        end
      end
      n_cmp++; if (mdu_ready_o !== exp_ready || rf_rd_s_o !== exp_rd_s || pipe_stall_o !== exp_stall) begin
        n_err++; $display("FAIL b2b_cyc%0d ready=%b rd=%0d stall=%b exp ready=%b rd=%0d stall=%b",
                          cyc, mdu_ready_o, rf_rd_s_o, pipe_stall_o, exp_ready, exp_rd_s, exp_stall);
      end
      if (pipe_stall_o === 1'b1) retired.push_back(int'(rf_rd_s_o));
      if (mv && exp_ready) idx++;
    end
    n_cmp++; if (retired.size() != 3) begin
      n_err++; $display("FAIL b2b_retire_count got=%0d exp=3 (cycle budget)", retired.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (retired[i] != i + 1) begin
          n_err++; $display("FAIL b2b_order slot=%0d got=%0d exp=%0d", i, retired[i], i + 1);
        end
      end
    end
  endtask

  task automatic test_x0_discard();
    do_reset();
    drive(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    n_cmp++; if (rf_we_o !== 1'b0 || mdu_ready_o !== 1'b1) begin
      n_err++; $display("FAIL x0_c0 we=%b ready=%b exp we=0 ready=1", rf_we_o, mdu_ready_o);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0);
      n_cmp++; if (rf_we_o !== 1'b0 || mdu_pending_o !== 1'b0) begin
        n_err++; $display("FAIL x0_after%0d we=%b pend=%b exp we=0 pend=0", k, rf_we_o, mdu_pending_o);
      end
    end
  endtask

  task automatic test_reset_flush();
    do_reset();
    drive(1'b0, 1'b1, 5'd4, 32'h4, 1'b1, 5'd11, 32'hB);
    drive(1'b0, 1'b1, 5'd4, 32'h4, 1'b1, 5'd12, 32'hC);
    drive(1'b0, 1'b1, 5'd4, 32'h4, 1'b0, '0, '0);
    n_cmp++; if (mdu_pending_o !== 1'b1 || mdu_ready_o !== 1'b0) begin
      n_err++; $display("FAIL flush_full pend=%b ready=%b exp pend=1 ready=0", mdu_pending_o, mdu_ready_o);
    end
    drive(1'b1, 1'b1, 5'd4, 32'h4, 1'b0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      idle();
      n_cmp++; if (rf_we_o !== 1'b0 || mdu_pending_o !== 1'b0 || mdu_ready_o !== 1'b1) begin
        n_err++; $display("FAIL flush_after%0d we=%b pend=%b ready=%b exp we=0 pend=0 ready=1",
                          k, rf_we_o, mdu_pending_o, mdu_ready_o);
      end
`ifdef ORION_WB_ARB_PERF_EN
      if (k == 0) begin
        n_cmp++; if (perf_conflict_o !== 32'd0 || perf_stall_o !== 32'd0) begin
          n_err++; $display("FAIL flush_perf conflict=%0d stall=%0d exp 0 0", perf_conflict_o, perf_stall_o);
        end
      end
`endif
    end
  endtask

  task automatic test_random();
    logic hold = 1'b0;
    logic mv = 1'b0;
    logic [RIB-1:0]  mrd = '0, prd;
    logic [XLEN-1:0] mdv = '0, pv;
    logic pwe;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        mv  = 1'($urandom_range(0, 1));
        mrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        mdv = $urandom;
      end
      pwe = ($urandom_range(0, 3) != 0);
      prd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pv  = $urandom;
      drive(1'b0, pwe, prd, pv, mv, mrd, mdv);
      n_cmp++; if (rf_we_o !== exp_we) begin n_err++; $display("FAIL rand%0d_we got=%b exp=%b", i, rf_we_o, exp_we); end
      n_cmp++; if (exp_we && (rf_rd_s_o !== exp_rd_s || rf_rd_v_o !== exp_rd_v)) begin
        n_err++; $display("FAIL rand%0d_port got=%0d/%h exp=%0d/%h", i, rf_rd_s_o, rf_rd_v_o, exp_rd_s, exp_rd_v);
      end
      n_cmp++; if (pipe_stall_o !== exp_stall) begin n_err++; $display("FAIL rand%0d_stall got=%b exp=%b", i, pipe_stall_o, exp_stall); end
      n_cmp++; if (mdu_ready_o !== exp_ready) begin n_err++; $display("FAIL rand%0d_ready got=%b exp=%b", i, mdu_ready_o, exp_ready); end
      n_cmp++; if (mdu_pending_o !== exp_pend) begin n_err++; $display("FAIL rand%0d_pend got=%b exp=%b", i, mdu_pending_o, exp_pend); end
`ifdef ORION_WB_ARB_PERF_EN
      n_cmp++; if (perf_conflict_o !== exp_conf || perf_stall_o !== exp_stalls) begin
        n_err++; $display("FAIL rand%0d_perf got=%0d/%0d exp=%0d/%0d", i, perf_conflict_o, perf_stall_o, exp_conf, exp_stalls);
      end
`endif
      hold = mv && !exp_ready;
    end
  endtask

  initial begin
    rst_i = 1'b1; pipe_we_i = 1'b0; pipe_rd_s_i = '0; pipe_rd_v_i = '0;
    mdu_valid_i = 1'b0; mdu_rd_s_i = '0; mdu_rd_v_i = '0;
    m_denied = 0; m_conf = 0; m_stalls = 0;
    test_reset();
    test_single_mdu();
    test_starvation();
    test_back_to_back();
    test_x0_discard();
    test_reset_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
